// File: rtl/flag_ctrl_if.sv
// rtl/flag_ctrl_if.sv - bundled ALU-flag, stack and condition signals for flag_ctrl
//   master: drives alu_valid, alu_c/z/b, upd_mask, clr, push, pop, cond_req, cond_sel
//   slave : drives flag_c/z/b, cond_valid, cond_true, stk_depth, stk_full, stk_empty, stk_err
interface flag_ctrl_if;
  logic       alu_valid;
  logic       alu_c;
  logic       alu_z;
  logic       alu_b;
  logic [2:0] upd_mask;
  logic       clr;
  logic       push;
  logic       pop;
  logic       cond_req;
  logic [2:0] cond_sel;
  logic       flag_c;
  logic       flag_z;
  logic       flag_b;
  logic       cond_valid;
  logic       cond_true;
  logic [3:0] stk_depth;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;

  modport master (
    output alu_valid, alu_c, alu_z, alu_b, upd_mask, clr, push, pop, cond_req, cond_sel,
    input  flag_c, flag_z, flag_b, cond_valid, cond_true, stk_depth, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  alu_valid, alu_c, alu_z, alu_b, upd_mask, clr, push, pop, cond_req, cond_sel,
    output flag_c, flag_z, flag_b, cond_valid, cond_true, stk_depth, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/flag_ctrl.sv
// rtl/flag_ctrl.sv - C/Z/B flag register with save stack and branch-condition evaluator
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : flag_ctrl_if.slave (ALU flag inputs, clr/push/pop, cond request; flag/stack/cond outputs)
module flag_ctrl #(
  parameter int STK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  flag_ctrl_if.slave  bus
);

  localparam int         AW        = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam logic [3:0] DEPTH_MAX = 4'(STK_DEPTH);

  // flags packed as {C, Z, B}
  logic [2:0]    flags_q, flags_d;
  logic [3:0]    depth_q, depth_d;
  logic          err_q, err_d;
  logic          cv_q, cv_d;
  logic          ct_q, ct_d;
  logic [2:0]    stk_q [STK_DEPTH];

  logic          full;
  logic          empty;
  logic          push_only;
  logic          pop_only;
  logic          push_ok;
  logic          pop_ok;
  logic          err_evt;
  logic [3:0]    depth_m1;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [2:0]    alu_flags;
  logic [2:0]    top_flags;

  assign full      = (depth_q == DEPTH_MAX);
  assign empty     = (depth_q == 4'd0);
  assign depth_m1  = depth_q - 4'd1;
  assign wr_idx    = depth_q[AW-1:0];
  assign rd_idx    = depth_m1[AW-1:0];
  assign alu_flags = {bus.alu_c, bus.alu_z, bus.alu_b};
  assign top_flags = stk_q[rd_idx];

  // push and pop together cancel each other and count as a conflict
  assign push_only = bus.push & ~bus.pop;
  assign pop_only  = bus.pop & ~bus.push;
  assign push_ok   = push_only & ~full;
  assign pop_ok    = pop_only & ~empty;
  assign err_evt   = (bus.push & bus.pop) | (push_only & full) | (pop_only & empty);

  always_comb begin
    flags_d = flags_q;
    depth_d = depth_q;
    err_d   = err_q | err_evt;
    cv_d    = bus.cond_req;
    ct_d    = 1'b0;

    // flag source priority: clr, then a successful pop, then the ALU
    if (bus.clr) begin
      flags_d = 3'b000;
    end else if (pop_ok) begin
      flags_d = top_flags;
    end else if (bus.alu_valid) begin
      flags_d = (alu_flags & bus.upd_mask) | (flags_q & ~bus.upd_mask);
    end

    // the stack still moves under clr; only the error flag is forced low
    if (push_ok) begin
      depth_d = depth_q + 4'd1;
    end else if (pop_ok) begin
      depth_d = depth_m1;
    end

    if (bus.clr) begin
      err_d = 1'b0;
    end

    // condition is judged on the flags being loaded at this edge
    if (bus.cond_req) begin
      case (bus.cond_sel)
        3'b000:  ct_d = 1'b1;
        3'b001:  ct_d = flags_d[2];
        3'b010:  ct_d = ~flags_d[2];
        3'b011:  ct_d = flags_d[1];
        3'b100:  ct_d = ~flags_d[1];
        3'b101:  ct_d = flags_d[0];
        3'b110:  ct_d = ~flags_d[0];
        default: ct_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= 3'b000;
      depth_q <= 4'd0;
      err_q   <= 1'b0;
      cv_q    <= 1'b0;
      ct_q    <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      cv_q    <= cv_d;
      ct_q    <= ct_d;
    end
  end

  // entry storage carries no reset; depth alone defines what is valid
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stk_q[wr_idx] <= flags_q;
    end
  end

  assign bus.flag_c     = flags_q[2];
  assign bus.flag_z     = flags_q[1];
  assign bus.flag_b     = flags_q[0];
  assign bus.cond_valid = cv_q;
  assign bus.cond_true  = ct_q;
  assign bus.stk_depth  = depth_q;
  assign bus.stk_full   = full;
  assign bus.stk_empty  = empty;
  assign bus.stk_err    = err_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// tb/tb_flag_ctrl.sv - table-driven self-checking bench for flag_ctrl
module tb_flag_ctrl;

  // exp = {flags C Z B, cond_valid, cond_true, depth[3:0], full, empty, err}
  typedef struct packed {
    logic        av;
    logic [2:0]  alu;
    logic [2:0]  mask;
    logic        clr;
    logic        push;
    logic        pop;
    logic        creq;
    logic [2:0]  sel;
    logic [11:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl [64];
  int   n_vec = 0;

  flag_ctrl_if bus ();

  flag_ctrl #(.STK_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] outs();
    return {bus.flag_c, bus.flag_z, bus.flag_b, bus.cond_valid, bus.cond_true,
            bus.stk_depth, bus.stk_full, bus.stk_empty, bus.stk_err};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (fl cv ct depth full empty err)", name, act, exp);
    end
  endtask

  task automatic add(input logic av, input logic [2:0] alu, input logic [2:0] mask,
                     input logic clr, input logic push, input logic pop,
                     input logic creq, input logic [2:0] sel,
                     input logic [2:0] fl, input logic cv, input logic ct,
                     input logic [3:0] dep, input logic full, input logic empty, input logic err);
    tbl[n_vec] = '{av, alu, mask, clr, push, pop, creq, sel,
                   {fl, cv, ct, dep, full, empty, err}};
    n_vec++;
  endtask

  task automatic drive(input vec_t v);
    bus.alu_valid = v.av;
    {bus.alu_c, bus.alu_z, bus.alu_b} = v.alu;
    bus.upd_mask  = v.mask;
    bus.clr       = v.clr;
    bus.push      = v.push;
    bus.pop       = v.pop;
    bus.cond_req  = v.creq;
    bus.cond_sel  = v.sel;
  endtask

  task automatic idle();
    vec_t v;
    v = '0;
    drive(v);
  endtask

  initial begin
    idle();

    //   av alu     mask    clr  push pop  creq sel   | flags  cv   ct   dep   full empty err
    add(1, 3'b111, 3'b100, 0, 0, 0, 0, 3'b000, 3'b100, 0, 0, 4'd0, 0, 1, 0); // mask C only
    add(1, 3'b011, 3'b011, 0, 0, 0, 0, 3'b000, 3'b111, 0, 0, 4'd0, 0, 1, 0); // mask Z,B
    add(0, 3'b000, 3'b111, 0, 0, 0, 0, 3'b000, 3'b111, 0, 0, 4'd0, 0, 1, 0); // no valid: hold
    add(0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 4'd0, 0, 1, 0); // clr
    add(1, 3'b101, 3'b111, 0, 0, 0, 0, 3'b000, 3'b101, 0, 0, 4'd0, 0, 1, 0);
    add(0, 3'b000, 3'b000, 0, 1, 0, 0, 3'b000, 3'b101, 0, 0, 4'd1, 0, 0, 0); // push 101
    add(1, 3'b010, 3'b111, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0, 4'd1, 0, 0, 0);
    add(0, 3'b000, 3'b000, 0, 0, 1, 0, 3'b000, 3'b101, 0, 0, 4'd0, 0, 1, 0); // pop -> 101
    add(1, 3'b000, 3'b111, 0, 1, 0, 0, 3'b000, 3'b000, 0, 0, 4'd1, 0, 0, 0); // push pre-edge + ALU
    add(1, 3'b111, 3'b111, 0, 0, 1, 0, 3'b000, 3'b101, 0, 0, 4'd0, 0, 1, 0); // pop beats ALU
    add(1, 3'b010, 3'b111, 0, 0, 0, 1, 3'b011, 3'b010, 1, 1, 4'd0, 0, 1, 0); // Z post-update
    add(0, 3'b000, 3'b000, 0, 0, 0, 1, 3'b111, 3'b010, 1, 0, 4'd0, 0, 1, 0); // never
    add(0, 3'b000, 3'b000, 0, 0, 0, 1, 3'b001, 3'b010, 1, 0, 4'd0, 0, 1, 0); // C
    add(0, 3'b000, 3'b000, 0, 0, 0, 1, 3'b010, 3'b010, 1, 1, 4'd0, 0, 1, 0); // !C
    add(0, 3'b000, 3'b000, 0, 0, 0, 1, 3'b100, 3'b010, 1, 0, 4'd0, 0, 1, 0); // !Z
    add(0, 3'b000, 3'b000, 0, 0, 0, 1, 3'b101, 3'b010, 1, 0, 4'd0, 0, 1, 0); // B
    add(0, 3'b000, 3'b000, 0, 0, 0, 1, 3'b110, 3'b010, 1, 1, 4'd0, 0, 1, 0); // !B
    add(0, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 3'b010, 1, 1, 4'd0, 0, 1, 0); // always
    add(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0, 4'd0, 0, 1, 0); // pulse ends
    add(0, 3'b000, 3'b000, 0, 1, 1, 0, 3'b000, 3'b010, 0, 0, 4'd0, 0, 1, 1); // push+pop conflict
    add(0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 4'd0, 0, 1, 0); // clr err
    add(1, 3'b001, 3'b111, 0, 1, 0, 0, 3'b000, 3'b001, 0, 0, 4'd1, 0, 0, 0); // e0=000
    add(1, 3'b010, 3'b111, 0, 1, 0, 0, 3'b000, 3'b010, 0, 0, 4'd2, 0, 0, 0); // e1=001
    add(1, 3'b011, 3'b111, 0, 1, 0, 0, 3'b000, 3'b011, 0, 0, 4'd3, 0, 0, 0); // e2=010
    add(1, 3'b100, 3'b111, 0, 1, 0, 0, 3'b000, 3'b100, 0, 0, 4'd4, 1, 0, 0); // e3=011
    add(1, 3'b110, 3'b111, 0, 1, 0, 0, 3'b000, 3'b110, 0, 0, 4'd4, 1, 0, 1); // overflow, ALU applies
    add(0, 3'b000, 3'b000, 1, 1, 0, 0, 3'b000, 3'b000, 0, 0, 4'd4, 1, 0, 0); // clr+push at full
    add(0, 3'b000, 3'b000, 1, 0, 1, 0, 3'b000, 3'b000, 0, 0, 4'd3, 0, 0, 0); // clr+pop: stack moves
    add(0, 3'b000, 3'b000, 0, 0, 1, 0, 3'b000, 3'b010, 0, 0, 4'd2, 0, 0, 0);
    add(0, 3'b000, 3'b000, 0, 0, 1, 0, 3'b000, 3'b001, 0, 0, 4'd1, 0, 0, 0);
    add(0, 3'b000, 3'b000, 0, 0, 1, 0, 3'b000, 3'b000, 0, 0, 4'd0, 0, 1, 0);
    add(1, 3'b111, 3'b111, 0, 0, 1, 0, 3'b000, 3'b111, 0, 0, 4'd0, 0, 1, 1); // underflow, ALU applies
    add(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 3'b111, 0, 0, 4'd0, 0, 1, 1); // err sticky
    add(0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 4'd0, 0, 1, 0);
    add(1, 3'b111, 3'b111, 0, 1, 0, 0, 3'b000, 3'b111, 0, 0, 4'd1, 0, 0, 0);
    add(1, 3'b111, 3'b111, 0, 1, 0, 0, 3'b000, 3'b111, 0, 0, 4'd2, 0, 0, 0);
    add(1, 3'b111, 3'b111, 0, 1, 0, 0, 3'b000, 3'b111, 0, 0, 4'd3, 0, 0, 0);

    // reset state while held, then release between edges
    #12;
    check("reset_hold", outs(), 12'b000_0_0_0000_0_1_0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", outs(), 12'b000_0_0_0000_0_1_0);

    for (int i = 0; i < n_vec; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // pending cond result, then async reset mid-cycle with depth 3, flags 111
    bus.push     = 1'b0;
    bus.alu_valid = 1'b0;
    bus.cond_req = 1'b1;
    bus.cond_sel = 3'b000;
    @(posedge clk);
    #1;
    check("cond_pending", outs(), 12'b111_1_1_0011_0_0_0);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", outs(), 12'b000_0_0_0000_0_1_0);
    idle();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("no_stale_cond", outs(), 12'b000_0_0_0000_0_1_0);
    @(posedge clk);
    #1;
    check("no_stale_cond2", outs(), 12'b000_0_0_0000_0_1_0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
